// File: rtl/sgpr_wr_port_arbiter.sv
// Round-robin arbiter for the single SGPR write port. Inserts a one-cycle bubble
// when the next winner's dword range overlaps the grant currently in flight.
module sgpr_wr_port_arbiter #(
  parameter int NUM_REQ    = 10,
  parameter int ADDR_WIDTH = 9,
  parameter int SEL_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_req_addr,
  output logic [SEL_WIDTH-1:0]          wr_select,
  output logic                          wr_grant_valid,
  output logic                          hazard_stall,
  output logic [3:0]                    last_grant_id
);

  localparam int ID_W    = 4;
  localparam int LSU_IDX = 8;
  localparam int EXT_W   = ADDR_WIDTH + 1;

  // Ranges use one extra bit so that addr 511 + span never aliases to 0.
  localparam logic [EXT_W-1:0] SPAN_LSU = EXT_W'(4);
  localparam logic [EXT_W-1:0] SPAN_STD = EXT_W'(2);

  typedef enum logic {
    IDLE_OR_GRANT = 1'b0,
    STALL         = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [ID_W-1:0]        last_id_q, last_id_d;
  logic                   prev_valid_q, prev_valid_d;
  logic [EXT_W-1:0]       prev_lo_q, prev_lo_d;
  logic [EXT_W-1:0]       prev_end_q, prev_end_d;

  logic [NUM_REQ-1:0]     eligible;
  logic                   win_found;
  logic [ID_W-1:0]        win_id;
  logic [ID_W-1:0]        cand_id;
  int                     cand;
  int                     win_base;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [EXT_W-1:0]       win_lo;
  logic [EXT_W-1:0]       win_end;
  logic                   overlap;
  logic                   do_grant;

  // The port granted this cycle is writing now, so it cannot win again until next cycle.
  assign eligible = wr_req & ~sel_q[NUM_REQ-1:0];

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    cand_id   = '0;
    // Walk from the farthest offset down so the nearest eligible index is the last written.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = int'(ptr_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_id = ID_W'(cand);
      if (eligible[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  always_comb begin
    win_base = int'(win_id) * ADDR_WIDTH;
    win_addr = wr_req_addr[win_base +: ADDR_WIDTH];
    win_lo   = {1'b0, win_addr};
    win_end  = win_lo + ((win_id == ID_W'(LSU_IDX)) ? SPAN_LSU : SPAN_STD);
  end

  // Half-open intervals [lo, end) overlap iff each starts before the other ends.
  assign overlap = prev_valid_q && (win_lo < prev_end_q) && (prev_lo_q < win_end);

  always_comb begin
    state_d      = IDLE_OR_GRANT;
    do_grant     = 1'b0;
    ptr_d        = ptr_q;
    sel_d        = '0;
    last_id_d    = last_id_q;
    prev_valid_d = 1'b0;
    prev_lo_d    = prev_lo_q;
    prev_end_d   = prev_end_q;

    unique case (state_q)
      IDLE_OR_GRANT: begin
        if (win_found) begin
          if (overlap) state_d = STALL;
          else         do_grant = 1'b1;
        end
      end
      STALL: begin
        // Nothing is in flight during the bubble, so the re-evaluated winner is granted.
        do_grant = win_found;
      end
      default: state_d = IDLE_OR_GRANT;
    endcase

    if (do_grant) begin
      sel_d[win_id] = 1'b1;
      ptr_d         = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      last_id_d     = win_id;
      prev_valid_d  = 1'b1;
      prev_lo_d     = win_lo;
      prev_end_d    = win_end;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE_OR_GRANT;
      ptr_q        <= '0;
      sel_q        <= '0;
      last_id_q    <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      last_id_q    <= last_id_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  // NOTE: the address range is only read when prev_valid_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    prev_lo_q  <= prev_lo_d;
    prev_end_q <= prev_end_d;
  end

  assign wr_select      = sel_q;
  assign wr_grant_valid = |sel_q;
  assign hazard_stall   = (state_q == STALL);
  assign last_grant_id  = last_id_q;

endmodule

// File: tb/tb_sgpr_wr_port_arbiter.sv
// Directed bench for sgpr_wr_port_arbiter: grant order, overlap bubbles, span edges
// and reset while a bubble is pending.
module tb_sgpr_wr_port_arbiter;

  localparam int NUM_REQ    = 10;
  localparam int ADDR_WIDTH = 9;
  localparam int SEL_WIDTH  = 16;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_REQ-1:0]            wr_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_req_addr;
  logic [SEL_WIDTH-1:0]          wr_select;
  logic                          wr_grant_valid;
  logic                          hazard_stall;
  logic [3:0]                    last_grant_id;

  int n_checks = 0;
  int n_errors = 0;

  sgpr_wr_port_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_req         (wr_req),
    .wr_req_addr    (wr_req_addr),
    .wr_select      (wr_select),
    .wr_grant_valid (wr_grant_valid),
    .hazard_stall   (hazard_stall),
    .last_grant_id  (last_grant_id)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] sel_exp,
                            input logic hz_exp, input logic [3:0] last_exp);
    check({tag, ".sel"},   32'(wr_select),      32'(sel_exp));
    check({tag, ".valid"}, 32'(wr_grant_valid), 32'(sel_exp != 16'h0));
    check({tag, ".stall"}, 32'(hazard_stall),   32'(hz_exp));
    check({tag, ".last"},  32'(last_grant_id),  32'(last_exp));
  endtask

  task automatic set_addr(input int idx, input logic [8:0] a);
    wr_req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH] = a;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    wr_req = '0;
    cyc();
    rst    = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    wr_req      = '0;
    wr_req_addr = '0;
    cyc();
    cyc();
    check_outs("reset", 16'h0000, 1'b0, 4'd0);

    // Single simd0 request: granted one cycle later.
    rst    = 1'b0;
    wr_req = 10'h001;
    set_addr(0, 9'd4);
    cyc();
    check_outs("single_grant", 16'h0001, 1'b0, 4'd0);
    wr_req = '0;
    cyc();
    check_outs("single_idle", 16'h0000, 1'b0, 4'd0);

    // All ten requesting with disjoint addresses: strict round-robin, no stalls.
    do_reset();
    wr_req = 10'h3FF;
    for (int i = 0; i < NUM_REQ; i++) set_addr(i, 9'(i * 8));
    for (int k = 0; k <= NUM_REQ; k++) begin
      cyc();
      check_outs($sformatf("rr_%0d", k), 16'(1 << (k % NUM_REQ)), 1'b0, 4'(k % NUM_REQ));
    end
    wr_req = '0;
    cyc();
    check_outs("rr_idle", 16'h0000, 1'b0, 4'd0);

    // simd0 @10 then simf0 @11: overlap -> one bubble, then simf0.
    do_reset();
    wr_req = 10'h001;
    set_addr(0, 9'd10);
    cyc();
    check_outs("ovl_first", 16'h0001, 1'b0, 4'd0);
    wr_req = 10'h010;
    set_addr(4, 9'd11);
    cyc();
    check_outs("ovl_bubble", 16'h0000, 1'b1, 4'd0);
    cyc();
    check_outs("ovl_after", 16'h0010, 1'b0, 4'd4);
    wr_req = '0;
    cyc();
    check_outs("ovl_idle", 16'h0000, 1'b0, 4'd4);

    // lsu @20 spans [20,23]: salu @24 is clear, salu @23 collides.
    do_reset();
    wr_req = 10'h100;
    set_addr(8, 9'd20);
    cyc();
    check_outs("lsu_a", 16'h0100, 1'b0, 4'd8);
    wr_req = 10'h200;
    set_addr(9, 9'd24);
    cyc();
    check_outs("salu_24", 16'h0200, 1'b0, 4'd9);
    wr_req = 10'h100;
    cyc();
    check_outs("lsu_b", 16'h0100, 1'b0, 4'd8);
    wr_req = 10'h200;
    set_addr(9, 9'd23);
    cyc();
    check_outs("salu_23_bubble", 16'h0000, 1'b1, 4'd8);
    cyc();
    check_outs("salu_23", 16'h0200, 1'b0, 4'd9);
    wr_req = '0;
    cyc();

    // simd2 @511 then simd3 @0: no wraparound, back-to-back grants.
    do_reset();
    wr_req = 10'h004;
    set_addr(2, 9'd511);
    cyc();
    check_outs("top_511", 16'h0004, 1'b0, 4'd2);
    wr_req = 10'h008;
    set_addr(3, 9'd0);
    cyc();
    check_outs("nowrap_0", 16'h0008, 1'b0, 4'd3);
    wr_req = '0;
    cyc();

    // Stalled simf0 is not bypassed by a clear salu; salu follows afterwards.
    do_reset();
    wr_req = 10'h001;
    set_addr(0, 9'd10);
    cyc();
    check_outs("nobyp_first", 16'h0001, 1'b0, 4'd0);
    wr_req = 10'h210;
    set_addr(4, 9'd11);
    set_addr(9, 9'd100);
    cyc();
    check_outs("nobyp_bubble", 16'h0000, 1'b1, 4'd0);
    cyc();
    check_outs("nobyp_winner", 16'h0010, 1'b0, 4'd4);
    wr_req = 10'h200;
    cyc();
    check_outs("nobyp_salu", 16'h0200, 1'b0, 4'd9);
    wr_req = '0;
    cyc();
    check_outs("nobyp_idle", 16'h0000, 1'b0, 4'd9);

    // Stalled simf0 drops its request during the bubble: salu wins instead.
    do_reset();
    wr_req = 10'h001;
    set_addr(0, 9'd10);
    cyc();
    check_outs("drop_first", 16'h0001, 1'b0, 4'd0);
    wr_req = 10'h210;
    cyc();
    check_outs("drop_bubble", 16'h0000, 1'b1, 4'd0);
    wr_req = 10'h200;
    cyc();
    check_outs("drop_salu", 16'h0200, 1'b0, 4'd9);
    wr_req = '0;
    cyc();

    // Reset in a bubble cycle cancels the stall and restarts the search from index 0.
    do_reset();
    wr_req = 10'h002;
    set_addr(1, 9'd10);
    cyc();
    check_outs("rst_first", 16'h0002, 1'b0, 4'd1);
    wr_req = 10'h010;
    set_addr(4, 9'd11);
    cyc();
    check_outs("rst_bubble", 16'h0000, 1'b1, 4'd1);
    rst    = 1'b1;
    wr_req = 10'h011;
    set_addr(0, 9'd200);
    cyc();
    check_outs("rst_held", 16'h0000, 1'b0, 4'd0);
    rst = 1'b0;
    cyc();
    check_outs("rst_restart", 16'h0001, 1'b0, 4'd0);
    wr_req = '0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
